// File: rtl/instr_cache_controller.sv
// -----------------------------------------------------------------------------
// instr_cache_controller
//
// Control block for the direct-mapped instruction cache in the fetch stage.
// Decodes the fetch set index into a one-hot active-set vector, selects that
// set's miss flag as the fetch-stage miss, and gates the line-fill
// (replacement) enable when a fetch miss coincides with a branch in Execute,
// so that a wrong-path line is never filled after a misprediction.
//
// Ports:
//   clk_i                 in   1   core clock, rising-edge state updates
//   reset_i               in   1   synchronous active-high reset
//   set_i                 in   6   set index of current fetch address
//   miss_array_i          in  64   per-set miss flags (bit n = set n misses)
//   pc_src_reg_i          in   2   registered PC source; bit 1 = redirect taken
//   branch_op_e_i         in   2   Execute branch op; bit 0 = branch/jump present
//   active_array_o        out 64   one-hot set select
//   instr_miss_f_o        out  1   fetch miss = miss_array_i[set_i]
//   instr_cache_rep_en_o  out  1   replacement enable, 1 = fill permitted
// -----------------------------------------------------------------------------
module instr_cache_controller (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [5:0]  set_i,
    input  logic [63:0] miss_array_i,
    input  logic [1:0]  pc_src_reg_i,
    input  logic [1:0]  branch_op_e_i,
    output logic [63:0] active_array_o,
    output logic        instr_miss_f_o,
    output logic        instr_cache_rep_en_o
);

    typedef enum logic {
        ST_IDLE        = 1'b0,
        ST_BRANCH_WAIT = 1'b1
    } state_t;

    state_t present_state;
    state_t next_state;

    logic branch_e;
    logic redirect_taken;
    logic branch_miss;

    // Only bit 0 of the branch op and bit 1 of the PC source carry meaning;
    // the other bits are folded here so they are visibly consumed.
    logic unused_bits;
    assign unused_bits = &{1'b0, pc_src_reg_i[0], branch_op_e_i[1]};

    assign branch_e       = branch_op_e_i[0];
    assign redirect_taken = pc_src_reg_i[1];

    // Set decode and miss select are independent of the FSM and of reset.
    assign active_array_o = 64'd1 << set_i;
    assign instr_miss_f_o = miss_array_i[set_i];

    assign branch_miss = branch_e & instr_miss_f_o;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            present_state <= ST_IDLE;
        end else begin
            present_state <= next_state;
        end
    end

    // Next state and replacement enable
    always_comb begin
        next_state           = ST_IDLE;
        instr_cache_rep_en_o = 1'b1;
        case (present_state)
            ST_IDLE: begin
                // A miss under an unresolved branch may be on the wrong path:
                // hold the fill off now and decide once the branch resolves.
                instr_cache_rep_en_o = ~branch_miss;
                next_state           = branch_miss ? ST_BRANCH_WAIT : ST_IDLE;
            end
            ST_BRANCH_WAIT: begin
                // Branch now resolved: fill only if no redirect was taken.
                // Always a single-cycle hold, even if a new branch-miss shows up.
                instr_cache_rep_en_o = ~redirect_taken;
                next_state           = ST_IDLE;
            end
            default: begin
                instr_cache_rep_en_o = 1'b1;
                next_state           = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_cache_controller.sv
module tb_instr_cache_controller;

    logic        clk_i;
    logic        reset_i;
    logic [5:0]  set_i;
    logic [63:0] miss_array_i;
    logic [1:0]  pc_src_reg_i;
    logic [1:0]  branch_op_e_i;
    logic [63:0] active_array_o;
    logic        instr_miss_f_o;
    logic        instr_cache_rep_en_o;

    int n_tests;
    int n_fail;

    instr_cache_controller dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .set_i                (set_i),
        .miss_array_i         (miss_array_i),
        .pc_src_reg_i         (pc_src_reg_i),
        .branch_op_e_i        (branch_op_e_i),
        .active_array_o       (active_array_o),
        .instr_miss_f_o       (instr_miss_f_o),
        .instr_cache_rep_en_o (instr_cache_rep_en_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [5:0]  set;
        logic [63:0] ma;
        logic [1:0]  pc;
        logic [1:0]  br;
        logic        st;   // expected state before the edge
        logic        en;   // expected enable before the edge
    } vec_t;

    vec_t tbl[18];

    // Reference model: "waiting" means the previous edge saw a miss under a
    // branch while not already waiting (and not in reset).
    logic model_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_onehot(input logic [5:0] s);
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = (i == int'(s));
        return v;
    endfunction

    function automatic logic exp_miss(input logic [63:0] ma, input logic [5:0] s);
        return ((ma >> s) & 64'd1) != 64'd0;
    endfunction

    function automatic logic exp_en(input logic w, input logic [63:0] ma, input logic [5:0] s,
                                    input logic [1:0] pc, input logic [1:0] br);
        if (w) return !pc[1];
        return !(br[0] && exp_miss(ma, s));
    endfunction

    task automatic apply(input logic r, input logic [5:0] s, input logic [63:0] ma,
                         input logic [1:0] pc, input logic [1:0] br);
        reset_i       = r;
        set_i         = s;
        miss_array_i  = ma;
        pc_src_reg_i  = pc;
        branch_op_e_i = br;
    endtask

    task automatic clock_and_model();
        @(posedge clk_i);
        model_wait = reset_i ? 1'b0 : (!model_wait && branch_op_e_i[0] &&
                                       exp_miss(miss_array_i, set_i));
        @(negedge clk_i);
    endtask

    initial begin
        logic st_act;
        n_tests    = 0;
        n_fail     = 0;
        model_wait = 1'b0;
        apply(1'b1, 6'd0, 64'h0, 2'b00, 2'b00);
        @(negedge clk_i);

        // Decode sweep under reset
        for (int i = 0; i < 64; i++) begin
            apply(1'b1, 6'(i), 64'h0123456789ABCDEF, 2'b00, 2'b00);
            #1;
            check($sformatf("decode_active[%0d]", i), active_array_o, exp_onehot(6'(i)));
            check($sformatf("decode_miss[%0d]", i), {63'd0, instr_miss_f_o},
                  {63'd0, exp_miss(64'h0123456789ABCDEF, 6'(i))});
            check($sformatf("reset_en[%0d]", i), {63'd0, instr_cache_rep_en_o}, 64'd1);
            clock_and_model();
        end
        st_act = dut.present_state;
        check("reset_state", {63'd0, st_act}, 64'd0);

        // Directed multi-cycle table
        tbl[0]  = '{1'b0, 6'd3,  64'h0,      2'b00, 2'b00, 1'b0, 1'b1}; // hit
        tbl[1]  = '{1'b0, 6'd3,  '1,         2'b00, 2'b00, 1'b0, 1'b1}; // miss, no branch
        tbl[2]  = '{1'b0, 6'd9,  64'h0,      2'b00, 2'b01, 1'b0, 1'b1}; // branch hit
        tbl[3]  = '{1'b0, 6'd9,  '1,         2'b00, 2'b01, 1'b0, 1'b0}; // branch miss
        tbl[4]  = '{1'b0, 6'd9,  '1,         2'b00, 2'b00, 1'b1, 1'b1}; // correct predict
        tbl[5]  = '{1'b0, 6'd9,  '1,         2'b00, 2'b00, 1'b0, 1'b1}; // back idle
        tbl[6]  = '{1'b0, 6'd40, '1,         2'b00, 2'b01, 1'b0, 1'b0}; // branch miss
        tbl[7]  = '{1'b0, 6'd40, '1,         2'b10, 2'b01, 1'b1, 1'b0}; // mispredict, new b-miss
        tbl[8]  = '{1'b0, 6'd40, '1,         2'b00, 2'b00, 1'b0, 1'b1}; // must be idle
        tbl[9]  = '{1'b0, 6'd63, '1,         2'b01, 2'b01, 1'b0, 1'b0}; // pc[0] ignored
        tbl[10] = '{1'b0, 6'd63, '1,         2'b01, 2'b11, 1'b1, 1'b1}; // br[1] ignored
        tbl[11] = '{1'b0, 6'd63, '1,         2'b00, 2'b10, 1'b0, 1'b1}; // br[1] only
        tbl[12] = '{1'b0, 6'd0,  '1,         2'b00, 2'b01, 1'b0, 1'b0}; // enter wait
        tbl[13] = '{1'b1, 6'd0,  '1,         2'b10, 2'b01, 1'b1, 1'b0}; // reset in wait
        tbl[14] = '{1'b0, 6'd0,  64'h0,      2'b00, 2'b01, 1'b0, 1'b1}; // idle after reset
        tbl[15] = '{1'b0, 6'd16, 64'h20000,  2'b00, 2'b01, 1'b0, 1'b1}; // neighbour set hit
        tbl[16] = '{1'b0, 6'd17, 64'h20000,  2'b00, 2'b01, 1'b0, 1'b0}; // exact set miss
        tbl[17] = '{1'b0, 6'd17, 64'h0,      2'b00, 2'b00, 1'b1, 1'b1}; // wait, no redirect

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].rst, tbl[i].set, tbl[i].ma, tbl[i].pc, tbl[i].br);
            #1;
            st_act = dut.present_state;
            check($sformatf("tbl_state[%0d]", i), {63'd0, st_act}, {63'd0, tbl[i].st});
            check($sformatf("tbl_en[%0d]", i), {63'd0, instr_cache_rep_en_o}, {63'd0, tbl[i].en});
            check($sformatf("tbl_active[%0d]", i), active_array_o, exp_onehot(tbl[i].set));
            clock_and_model();
        end
        // After tbl[17] the FSM must have returned to idle.
        apply(1'b0, 6'd5, 64'h0, 2'b10, 2'b00);
        #1;
        st_act = dut.present_state;
        check("tbl_final_state", {63'd0, st_act}, 64'd0);
        check("tbl_final_en", {63'd0, instr_cache_rep_en_o}, 64'd1);
        clock_and_model();

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] ma;
            ma = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ma = '1;
            apply(($urandom_range(0, 15) == 0), 6'($urandom_range(0, 63)), ma,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            #1;
            st_act = dut.present_state;
            check("rnd_state", {63'd0, st_act}, {63'd0, model_wait});
            check("rnd_active", active_array_o, exp_onehot(set_i));
            check("rnd_miss", {63'd0, instr_miss_f_o}, {63'd0, exp_miss(miss_array_i, set_i)});
            check("rnd_en", {63'd0, instr_cache_rep_en_o},
                  {63'd0, exp_en(model_wait, miss_array_i, set_i, pc_src_reg_i, branch_op_e_i)});
            clock_and_model();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
